io_event_scheduler: RTL

Controller for a bank of registered input cells in the AP3 IO fabric. Sequences the cells' register reset after power-up or on request. Synchronises and debounces each cell's output, and detects enabled edges. Arbitrates the resulting per-pin events round-robin onto one valid/ready event port for the fabric-side consumer.

---
 rtl/io_event_scheduler.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/io_event_scheduler.sv
// rtl/io_event_scheduler.sv - AP3 input-cell reset sequencer, per-pin debounce/edge detect and round-robin event arbiter
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   iqz[N_IO]           : registered outputs of the input cells (asynchronous, synchronised here)
//   io_rst              : active-high register reset driven to the cells
//   en[N_IO]            : per-pin event enable
//   rise_en, fall_en    : report 0->1 / 1->0 transitions of the debounced level
//   flush               : single-cycle request to re-initialise the cells and drop queued events
//   evt_valid/evt_ready : event handshake to the fabric-side consumer
//   evt_idx, evt_level  : pin index and new debounced level of the presented event
//   ovf[N_IO], ovf_clr  : sticky per-pin lost-event flags and their clear

module io_event_scheduler #(
    parameter int N_IO     = 8,
    parameter int DEBOUNCE = 4,
    parameter int INIT_CYC = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IO-1:0]         iqz,
    output logic                    io_rst,
    input  logic [N_IO-1:0]         en,
    input  logic                    rise_en,
    input  logic                    fall_en,
    input  logic                    flush,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_IO)-1:0] evt_idx,
    output logic                    evt_level,
    output logic [N_IO-1:0]         ovf,
    input  logic                    ovf_clr
);

    localparam int IW = $clog2(N_IO);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      init_cnt, init_cnt_nxt;

    logic [N_IO-1:0] sync1, sync2;
    logic [N_IO-1:0] stable, stable_nxt;
    logic [3:0]      deb [N_IO];
    logic [3:0]      deb_nxt [N_IO];
    logic [N_IO-1:0] upd;
    logic [N_IO-1:0] new_evt;

    logic [N_IO-1:0] pend, pend_nxt;
    logic [N_IO-1:0] pend_lvl, pend_lvl_nxt;
    logic [N_IO-1:0] ovf_set;
    logic [N_IO-1:0] grant_oh;

    logic [IW-1:0]   last_grant, last_grant_nxt;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   pos;
    logic            grant_found;
    logic            load;

    logic            valid_nxt;
    logic [IW-1:0]   idx_nxt;
    logic            level_nxt;

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        if (flush) begin
            state_nxt    = S_INIT;
            init_cnt_nxt = '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt == 4'(INIT_CYC - 1)) begin
                        state_nxt    = S_PRIME;
                        init_cnt_nxt = '0;
                    end else begin
                        init_cnt_nxt = init_cnt + 4'd1;
                    end
                end
                S_PRIME: state_nxt = S_RUN;
                S_RUN:   state_nxt = S_RUN;
                default: state_nxt = S_INIT;
            endcase
        end
    end

    assign io_rst = (state == S_INIT);

    // ---------------- debounce and edge qualification ----------------
    // PRIME copies the synchronised level straight into stable so the
    // post-reset cell state never shows up as an event.
    always_comb begin
        stable_nxt = stable;
        upd        = '0;
        for (int i = 0; i < N_IO; i++) begin
            deb_nxt[i] = deb[i];
            if (flush) begin
                deb_nxt[i] = '0;
            end else if (state == S_PRIME) begin
                stable_nxt[i] = sync2[i];
            end else if (state == S_RUN) begin
                if (sync2[i] != stable[i]) begin
                    if (deb[i] == 4'(DEBOUNCE - 1)) begin
                        stable_nxt[i] = sync2[i];
                        deb_nxt[i]    = '0;
                        upd[i]        = 1'b1;
                    end else begin
                        deb_nxt[i] = deb[i] + 4'd1;
                    end
                end else begin
                    deb_nxt[i] = '0;
                end
            end
        end
    end

    // upd is only ever set in RUN without flush, so new_evt inherits that.
    always_comb begin
        for (int i = 0; i < N_IO; i++) begin
            new_evt[i] = upd[i] & en[i] & (sync2[i] ? rise_en : fall_en);
        end
    end

    // ---------------- round-robin arbiter ----------------
    assign load = !evt_valid || evt_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int k = 1; k <= N_IO; k++) begin
            pos = IW'((int'(last_grant) + k) % N_IO);
            if (!grant_found && pend[pos]) begin
                grant_found = 1'b1;
                grant_idx   = pos;
            end
        end
    end

    assign grant_oh = (load && grant_found) ? (N_IO'(1) << grant_idx) : '0;

    // A pin granted this cycle has its pending bit free again, so a fresh
    // event on it simply re-arms the bit rather than counting as a loss.
    always_comb begin
        pend_nxt     = (pend & ~grant_oh) | new_evt;
        ovf_set      = new_evt & pend & ~grant_oh;
        pend_lvl_nxt = pend_lvl;
        for (int i = 0; i < N_IO; i++) begin
            if (new_evt[i]) begin
                pend_lvl_nxt[i] = sync2[i];
            end
        end
        if (flush) begin
            pend_nxt     = '0;
            pend_lvl_nxt = '0;
            ovf_set      = '0;
        end
    end

    always_comb begin
        valid_nxt      = evt_valid;
        idx_nxt        = evt_idx;
        level_nxt      = evt_level;
        last_grant_nxt = last_grant;
        if (flush) begin
            valid_nxt = 1'b0;
        end else if (load) begin
            if (grant_found) begin
                valid_nxt      = 1'b1;
                idx_nxt        = grant_idx;
                level_nxt      = pend_lvl[grant_idx];
                last_grant_nxt = grant_idx;
            end else begin
                valid_nxt = 1'b0;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            pend       <= '0;
            pend_lvl   <= '0;
            ovf        <= '0;
            evt_valid  <= 1'b0;
            evt_idx    <= '0;
            evt_level  <= 1'b0;
            last_grant <= IW'(N_IO - 1);
            for (int i = 0; i < N_IO; i++) begin
                deb[i] <= '0;
            end
        end else begin
            sync1      <= iqz;
            sync2      <= sync1;
            stable     <= stable_nxt;
            pend       <= pend_nxt;
            pend_lvl   <= pend_lvl_nxt;
            // A clear never wins against an overflow landing in the same cycle.
            ovf        <= (ovf & ~{N_IO{ovf_clr}}) | ovf_set;
            evt_valid  <= valid_nxt;
            evt_idx    <= idx_nxt;
            evt_level  <= level_nxt;
            last_grant <= last_grant_nxt;
            for (int i = 0; i < N_IO; i++) begin
                deb[i] <= deb_nxt[i];
            end
        end
    end

endmodule
